mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Single-port front end for the synchronous 16-bit word Memory block.
- Arbitrates between an instruction-fetch requester (read-only) and a data requester (read/write).
- Drives the Memory's din/we/addr from registers and captures dout after the Memory's one-cycle read latency.
- Returns results to each requester over a req/ack handshake.

Parameters:
- DATA_W, 16: data word width; matches Memory din/dout.
- ADDR_W, 16: address width; matches Memory addr.
- MEM_WORDS, 1024: number of implemented Memory words. Used only by the optional range check.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  ADDR_W  fetch word address; stable while if_req is high.
- if_ack  output  1  one-cycle pulse; if_rdata is valid in that cycle.
- if_rdata  output  DATA_W  fetched word; held until the next fetch completes.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  input  ADDR_W  data word address.
- d_wdata  input  DATA_W  store data.
- d_ack  output  1  one-cycle completion pulse for both loads and stores.
- d_rdata  output  DATA_W  load result; held until the next load completes.
- mem_addr  output  ADDR_W  to Memory addr; registered.
- mem_din  output  DATA_W  to Memory din; registered.
- mem_we  output  1  to Memory we; registered, high for exactly one cycle per store.
- mem_dout  input  DATA_W  from Memory dout; valid the cycle after the edge that sampled mem_addr.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state IDLE; mem_addr 0; mem_din 0; mem_we 0; if_ack 0; d_ack 0; if_rdata 0; d_rdata 0; last_grant = FETCH.
- Reset mid-operation: state returns to IDLE and no ack is issued. A store whose mem_we was already high at the reset edge is written by Memory at that edge; this is accepted behaviour.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one requester high: that requester is granted.
  - Both high: the requester not equal to last_grant is granted. After reset, the first tie goes to data.
  - On grant: load mem_addr from the granted address. For a store, also set mem_din = d_wdata and mem_we = 1. Update last_grant. Go to ACCESS.
  - No request: stay in IDLE; mem_we stays 0.
- ACCESS: Memory samples mem_addr/mem_we at this edge.
  - Store: mem_we <= 0; d_ack <= 1; go to RESP.
  - Load or fetch: go to CAPTURE.
- CAPTURE: latch mem_dout into d_rdata (load) or if_rdata (fetch); assert the matching ack; go to RESP.
- RESP: ack is high for exactly this cycle. No new grant here, because the requester's req is still high in this cycle. Next edge: clear ack, go to IDLE.
- Latency, counted from the edge that samples req in IDLE to the edge that raises ack:
  - Store: 2 edges.
  - Load or fetch: 3 edges.
  - Busy periods: 3 cycles per store, 4 per read.
- Request still high after its ack is treated as a new request, sampled in the following IDLE cycle.
- mem_addr holds its last value between accesses; only mem_we gates writes.
- Addresses pass through unmodified. Upper-bit truncation against MEM_WORDS is the Memory's own behaviour unless the optional check is enabled.
- An ungranted requester keeps waiting. Round-robin guarantees service within one competing transaction.

Optional Feature:
- Macro: MEM_ACCESS_RANGE_CHECK_EN.
- Defined:
  - A granted address >= MEM_WORDS does not touch memory; mem_we stays 0.
  - The FSM still runs ACCESS/CAPTURE/RESP with normal latency.
  - Loads and fetches return 0.
  - Output port range_err (1 bit, reset 0) pulses high in the same cycle as the ack.
- Undefined: no range_err port; every address is forwarded to Memory unmodified.

Test Plan:
- Store 16'h1234 to address 0 via d_req/d_we=1: mem_we is high for exactly one cycle, d_ack pulses 2 edges after the request edge, busy deasserts after 3 cycles.
- Store 16'h4321 to 10 and 16'habcd to 1022, then load each: d_rdata = 16'h1234, 16'h4321, 16'habcd respectively, each ack 3 edges after its request edge.
- Fetch from address 10 while idle: if_ack pulses once, if_rdata = 16'h4321, d_ack stays 0, d_rdata is unchanged.
- if_req and d_req raised together, repeatedly, straight after reset: grants alternate data, fetch, data, fetch; neither ack is ever lost; mem_we is never high during a fetch.
- Assert reset during CAPTURE of a load: no d_ack, busy = 0 and all outputs at reset values next cycle; a subsequent load of address 0 returns 16'h1234.
- With MEM_ACCESS_RANGE_CHECK_EN: store to address 1024 gives mem_we = 0, d_ack plus range_err; a load from 1024 returns 0 with range_err; address 0 still reads 16'h1234.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port front end for the synchronous 16-bit word Memory.
// Arbitrates an instruction-fetch requester (read-only) and a data requester
// (read/write) round-robin, drives Memory din/we/addr from registers and
// captures dout one cycle after the Memory samples the address.
// Optional build macro: MEM_ACCESS_RANGE_CHECK_EN adds an address range check
// against MEM_WORDS and the range_err output.
module mem_access_unit #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
`ifdef MEM_ACCESS_RANGE_CHECK_EN
  output logic              range_err,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // A memory size of zero or one larger than the address space is a configuration error.
  if ((MEM_WORDS == 32'd0) || ((ADDR_W < 32'd32) && (MEM_WORDS > (32'd1 << ADDR_W)))) begin : g_mem_words_bad
    $error("mem_access_unit: MEM_WORDS must be in 1 .. 2**ADDR_W");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_d;      // 1: last grant went to data, 0: to fetch
  logic                r_cur_d;       // current transaction belongs to data requester
  logic                r_cur_store;   // current transaction is a store
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_din;
  logic                r_mem_we;
  logic                r_if_ack;
  logic                r_d_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_busy;
  logic                w_grant_d;
  logic                w_grant_if;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_store_we;

  // On a tie the requester that did not win last time is served.
  assign w_grant_d  = d_req & (~if_req | ~r_last_d);
  assign w_grant_if = if_req & ~w_grant_d;
  assign w_gnt_addr = w_grant_d ? d_addr : if_addr;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  logic r_addr_ok;
  logic r_range_err;
  logic w_addr_ok;
  // Out-of-range addresses never reach the Memory and read back as zero.
  assign w_addr_ok  = (32'(w_gnt_addr) < MEM_WORDS);
  assign w_store_we = w_grant_d & d_we & w_addr_ok;
  assign w_rdata    = r_addr_ok ? mem_dout : {DATA_W{1'b0}};
  assign range_err  = r_range_err;
`else
  assign w_store_we = w_grant_d & d_we;
  assign w_rdata    = mem_dout;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: stores skip CAPTURE, reads wait one cycle for Memory dout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d | w_grant_if) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_cur_store) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: w_state_nxt = ST_RESP;
      ST_RESP:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: grant bookkeeping, Memory drive, read capture and ack pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d    <= 1'b0;
      r_cur_d     <= 1'b0;
      r_cur_store <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_din   <= {DATA_W{1'b0}};
      r_mem_we    <= 1'b0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= {DATA_W{1'b0}};
      r_d_rdata   <= {DATA_W{1'b0}};
`ifdef MEM_ACCESS_RANGE_CHECK_EN
      r_addr_ok   <= 1'b0;
      r_range_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d | w_grant_if) begin
            r_last_d    <= w_grant_d;
            r_cur_d     <= w_grant_d;
            r_cur_store <= w_grant_d & d_we;
            r_mem_addr  <= w_gnt_addr;
            r_mem_we    <= w_store_we;
            if (w_grant_d & d_we) begin
              r_mem_din <= d_wdata;
            end
`ifdef MEM_ACCESS_RANGE_CHECK_EN
            r_addr_ok   <= w_addr_ok;
`endif
          end
        end
        ST_ACCESS: begin
          r_mem_we <= 1'b0;
          if (r_cur_store) begin
            r_d_ack <= 1'b1;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
            r_range_err <= ~r_addr_ok;
`endif
          end
        end
        ST_CAPTURE: begin
          if (r_cur_d) begin
            r_d_rdata <= w_rdata;
            r_d_ack   <= 1'b1;
          end else begin
            r_if_rdata <= w_rdata;
            r_if_ack   <= 1'b1;
          end
`ifdef MEM_ACCESS_RANGE_CHECK_EN
          r_range_err <= ~r_addr_ok;
`endif
        end
        ST_RESP: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
          r_range_err <= 1'b0;
`endif
        end
        default: begin
          r_mem_we <= 1'b0;
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
        end
      endcase
    end
  end

  // Registered busy flag tracks the state the FSM is entering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign if_ack   = r_if_ack;
  assign if_rdata = r_if_rdata;
  assign d_ack    = r_d_ack;
  assign d_rdata  = r_d_rdata;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_we   = r_mem_we;
  assign busy     = r_busy;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural Memory device and
// a transaction-timeline model of the expected outputs.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'd0;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = 16'd0;
  logic [15:0] d_wdata = 16'd0;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout;
  logic        busy;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
  logic        range_err;
`endif

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    .range_err(range_err),
`endif
    .busy(busy)
  );

  // Memory device: 1024 words, upper address bits ignored, one-cycle read latency.
  logic [15:0] ram [1024];
  initial for (int i = 0; i < 1024; i++) ram[i] = 16'd0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[9:0]] <= mem_din;
    mem_dout <= ram[mem_addr[9:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: one transaction at a time on a timeline ----------------
  logic [15:0] sb [1024];
  initial for (int i = 0; i < 1024; i++) sb[i] = 16'd0;
  logic        e_if_ack = 1'b0, e_d_ack = 1'b0, e_mem_we = 1'b0, e_busy = 1'b0, e_rerr = 1'b0;
  logic [15:0] e_if_rdata = 16'd0, e_d_rdata = 16'd0, e_mem_addr = 16'd0, e_mem_din = 16'd0;

  initial begin : model
    int   t;        // edges since the granting edge, 0 when idle
    int   lat;      // edge index (after grant) that raises the ack
    bit   last_d, cur_d, store, oor;
    logic [15:0] a, v;
    t = 0; lat = 0; last_d = 1'b0; cur_d = 1'b0; store = 1'b0; oor = 1'b0; a = 16'd0;
    forever begin
      @(posedge clk);
      if (reset) begin
        t = 0; last_d = 1'b0;
        e_if_ack = 1'b0; e_d_ack = 1'b0; e_mem_we = 1'b0; e_busy = 1'b0; e_rerr = 1'b0;
        e_if_rdata = 16'd0; e_d_rdata = 16'd0; e_mem_addr = 16'd0; e_mem_din = 16'd0;
      end else if (t == 0) begin
        if (d_req || if_req) begin
          cur_d  = d_req && (!if_req || !last_d);
          last_d = cur_d;
          store  = cur_d && d_we;
          a      = cur_d ? d_addr : if_addr;
          oor    = RANGE_EN && (a >= 16'd1024);
          e_mem_addr = a;
          if (store) e_mem_din = d_wdata;
          e_mem_we = store && !oor;
          if (store && !oor) sb[a[9:0]] = d_wdata;
          lat = store ? 1 : 2;
          t = 1;
          e_busy = 1'b1;
        end
      end else begin
        if (t == 1) e_mem_we = 1'b0;
        if (t == lat) begin
          v = oor ? 16'd0 : sb[a[9:0]];
          if (store) e_d_ack = 1'b1;
          else if (cur_d) begin e_d_ack = 1'b1; e_d_rdata = v; end
          else begin e_if_ack = 1'b1; e_if_rdata = v; end
          e_rerr = oor;
          t = t + 1;
        end else if (t == lat + 1) begin
          e_d_ack = 1'b0; e_if_ack = 1'b0; e_rerr = 1'b0; e_busy = 1'b0;
          t = 0;
        end else begin
          t = t + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare and event monitor ----------------
  int gr_seq[$];
  int we_cnt = 0;
  int dack_cnt = 0;
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("if_ack", if_ack, e_if_ack);
      chk("d_ack", d_ack, e_d_ack);
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
      chk("mem_addr", mem_addr, e_mem_addr);
      chk("mem_din", mem_din, e_mem_din);
      chk("mem_we", mem_we, e_mem_we);
      chk("busy", busy, e_busy);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
      chk("range_err", range_err, e_rerr);
`endif
      if (mem_we === 1'b1) we_cnt++;
      if (d_ack === 1'b1) begin dack_cnt++; gr_seq.push_back(1); end
      if (if_ack === 1'b1) gr_seq.push_back(2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle1();
    @(posedge clk); #1;
  endtask

  task automatic d_xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int exp_lat, output logic [15:0] rdata, output logic rerr);
    int n;
    bit got;
    n = 0; got = 1'b0;
    d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      if (d_ack === 1'b1) got = 1'b1;
    end
    rdata = d_rdata;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    rerr = range_err;
`else
    rerr = 1'b0;
`endif
    d_req = 1'b0;
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL d_timeout: got no d_ack expected d_ack within 20 cycles");
    end else if (exp_lat > 0) begin
      chk("d_latency", n, exp_lat);
    end
  endtask

  task automatic f_xact(input logic [15:0] addr, input int exp_lat, output logic [15:0] rdata);
    int n;
    bit got;
    n = 0; got = 1'b0;
    if_addr = addr; if_req = 1'b1;
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      if (if_ack === 1'b1) got = 1'b1;
    end
    rdata = if_rdata;
    if_req = 1'b0;
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL if_timeout: got no if_ack expected if_ack within 20 cycles");
    end else if (exp_lat > 0) begin
      chk("if_latency", n, exp_lat);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test expected end before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed test sequence ----------------
  initial begin : stim
    logic [15:0] rd;
    logic        re;
    int          w0, dk0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'd0);
    chk("rst_d_rdata", d_rdata, 16'd0);

    // Store 1234 to 0: one write cycle, ack after 2 edges, idle on the 3rd.
    idle1();
    w0 = we_cnt;
    d_xact(1'b1, 16'd0, 16'h1234, 2, rd, re);
    idle1();
    chk("store_busy_low", busy, 1'b0);
    chk("store_we_cycles", we_cnt - w0, 1);

    // Further stores, then read everything back.
    d_xact(1'b1, 16'd10, 16'h4321, 2, rd, re);   idle1();
    d_xact(1'b1, 16'd1022, 16'habcd, 2, rd, re); idle1();
    d_xact(1'b0, 16'd0, 16'd0, 3, rd, re);       idle1();
    chk("load_0", rd, 16'h1234);
    d_xact(1'b0, 16'd10, 16'd0, 3, rd, re);      idle1();
    chk("load_10", rd, 16'h4321);
    d_xact(1'b0, 16'd1022, 16'd0, 3, rd, re);    idle1();
    chk("load_1022", rd, 16'habcd);

    // Fetch while idle: data side untouched.
    dk0 = dack_cnt;
    f_xact(16'd10, 3, rd); idle1();
    chk("fetch_10", rd, 16'h4321);
    chk("fetch_no_dack", dack_cnt - dk0, 0);
    chk("fetch_d_rdata_kept", d_rdata, 16'habcd);

    // Reset while a load of 0 sits in CAPTURE.
    d_we = 1'b0; d_addr = 16'd0; d_req = 1'b1;
    idle1();              // ACCESS
    idle1();              // CAPTURE
    reset = 1'b1; d_req = 1'b0;
    idle1();
    chk("rst_cap_dack", d_ack, 1'b0);
    chk("rst_cap_busy", busy, 1'b0);
    chk("rst_cap_d_rdata", d_rdata, 16'd0);
    reset = 1'b0;
    d_xact(1'b0, 16'd0, 16'd0, 3, rd, re); idle1();
    chk("load_0_after_rst", rd, 16'h1234);

    // Simultaneous requests straight after reset: data, fetch, data, fetch ...
    reset = 1'b1; idle1(); reset = 1'b0;
    gr_seq.delete();
    for (int r = 0; r < 4; r++) begin
      fork
        begin
          logic [15:0] drd; logic dre;
          d_xact(((r % 2) == 0) ? 1'b1 : 1'b0, 16'd20, 16'h5a00 + 16'(r), -1, drd, dre);
        end
        begin
          logic [15:0] frd;
          f_xact(16'd10 + 16'(r), -1, frd);
        end
      join
      idle1();
    end
    chk("tie_count", gr_seq.size(), 8);
    for (int k = 0; k < 8 && k < gr_seq.size(); k++)
      chk("tie_order", gr_seq[k], ((k % 2) == 0) ? 1 : 2);

`ifdef MEM_ACCESS_RANGE_CHECK_EN
    w0 = we_cnt;
    d_xact(1'b1, 16'd1024, 16'hdead, 2, rd, re); idle1();
    chk("oor_store_we", we_cnt - w0, 0);
    chk("oor_store_rerr", re, 1'b1);
    d_xact(1'b0, 16'd1024, 16'd0, 3, rd, re); idle1();
    chk("oor_load_data", rd, 16'd0);
    chk("oor_load_rerr", re, 1'b1);
    d_xact(1'b0, 16'd0, 16'd0, 3, rd, re); idle1();
    chk("inrange_load_0", rd, 16'h1234);
    chk("inrange_rerr", re, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
